// File: rtl/ram_reader.sv
// Streaming read engine for the single-port RAM: reads a block of consecutive words
// and delivers them on a valid/ready stream, yielding the RAM to ram_init while ram_busy.
module ram_reader #(
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH   = READ_LATENCY + 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              ram_busy,
    input  logic [DATA_W-1:0] ram_q,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_wren,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_W-1:0]       base_q, base_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [ADDR_W:0]         issue_rem_q, issue_rem_d;
    logic [ADDR_W:0]         acc_rem_q, acc_rem_d;
    logic [READ_LATENCY-1:0] pipe_q, pipe_d;
    logic [CW-1:0]           inflight_q, inflight_d;
    logic [CW-1:0]           count_q, count_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]       mem_q [FIFO_DEPTH];

    logic [ADDR_W:0] len_c;
    logic            push;
    logic            pop;
    logic            credit_ok;
    logic            issue;

    assign len_c     = (length > MAX_LEN) ? MAX_LEN : length;
    assign push      = pipe_q[READ_LATENCY-1];
    assign pop       = (count_q != '0) && out_ready;
    assign credit_ok = ({1'b0, inflight_q} + {1'b0, count_q}) < (CW+1)'(FIFO_DEPTH);
    assign issue     = (state_q == S_ISSUE) && !ram_busy && credit_ok && (issue_rem_q != '0);

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        addr_d      = addr_q;
        issue_rem_d = issue_rem_q;
        acc_rem_d   = acc_rem_q - {{ADDR_W{1'b0}}, pop};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d      = base_addr;
                    issue_rem_d = len_c;
                    acc_rem_d   = len_c;
                    // Empty transfers pass through DRAIN so busy is seen for one cycle before done.
                    if (len_c == '0) begin
                        state_d = S_DRAIN;
                    end else if (ram_busy) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ISSUE;
                        addr_d  = base_addr;
                    end
                end
            end
            S_WAIT: begin
                if (!ram_busy) begin
                    state_d = S_ISSUE;
                    addr_d  = base_q;
                end
            end
            S_ISSUE: begin
                if (issue) begin
                    addr_d      = addr_q + 1'b1;
                    issue_rem_d = issue_rem_q - 1'b1;
                    if (issue_rem_q == (ADDR_W+1)'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (acc_rem_d == '0) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        pipe_d     = READ_LATENCY'({pipe_q, issue});
        inflight_d = inflight_q + CW'(issue) - CW'(push);
        count_d    = count_q + CW'(push) - CW'(pop);
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            base_q      <= '0;
            addr_q      <= '0;
            issue_rem_q <= '0;
            acc_rem_q   <= '0;
            pipe_q      <= '0;
            inflight_q  <= '0;
            count_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            addr_q      <= addr_d;
            issue_rem_q <= issue_rem_d;
            acc_rem_q   <= acc_rem_d;
            pipe_q      <= pipe_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= ram_q;
        end
    end

    assign ram_address = addr_q;
    assign ram_wren    = 1'b0;
    assign out_valid   = (count_q != '0);
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign busy        = (state_q == S_WAIT) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_ram_reader.sv
// Self-checking bench for ram_reader: behavioural RAM, directed timing cases and
// randomized transfers compared against a block-read reference model.
module tb_ram_reader;

    localparam int unsigned AW = 8;
    localparam int unsigned DW = 8;
    localparam int unsigned RL = 2;
    localparam int unsigned FD = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          ram_busy;
    logic [DW-1:0] ram_q;
    logic [AW-1:0] ram_address;
    logic          ram_wren;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          done;

    always #5 clock = ~clock;

    ram_reader #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .READ_LATENCY(RL),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .ram_busy   (ram_busy),
        .ram_q      (ram_q),
        .ram_address(ram_address),
        .ram_wren   (ram_wren),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .done       (done)
    );

    // RAM model: two registered stages from address to data
    logic [7:0] ram_mem [256];
    logic [7:0] rd1, rd2;
    always @(posedge clock) begin
        rd1 <= ram_mem[ram_address];
        rd2 <= rd1;
    end
    assign ram_q = rd2;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    bit         mon_en = 1'b0;
    int         t0;
    int         first_valid_rel;
    int         done_rel;
    int         done_cnt;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];

    always @(negedge clock) begin
        if (mon_en) begin
            if (prev_stall) check("hold", 32'(out_data), 32'(prev_data));
            if (out_valid && out_ready) got_q.push_back(out_data);
            if (out_valid && first_valid_rel == 0) first_valid_rel = cyc - t0 + 1;
            if (done) begin
                done_cnt++;
                done_rel = cyc - t0 + 1;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    task automatic fill_ram(input bit rnd);
        for (int a = 0; a < 256; a++) ram_mem[a] = rnd ? 8'($urandom) : (8'(a) ^ 8'h5A);
    endtask

    // Reference: the words a block read of len (clamped to 256) from base must yield
    task automatic build_exp(input logic [7:0] base, input logic [8:0] len);
        int n;
        exp_q.delete();
        n = (int'(len) > 256) ? 256 : int'(len);
        for (int i = 0; i < n; i++) exp_q.push_back(ram_mem[8'(int'(base) + i)]);
    endtask

    task automatic do_start(input logic [7:0] base, input logic [8:0] len);
        @(posedge clock); #1;
        got_q.delete();
        done_cnt        = 0;
        first_valid_rel = 0;
        done_rel        = 0;
        prev_stall      = 1'b0;
        build_exp(base, len);
        base_addr = base;
        length    = len;
        start     = 1'b1;
        @(posedge clock); #1;
        t0        = cyc;
        start     = 1'b0;
        base_addr = 8'($urandom);
        length    = 9'($urandom);
        mon_en    = 1'b1;
    endtask

    task automatic wait_done(input int budget, input int ready_pct, input int busy_pct);
        for (int c = 0; c < budget && done_cnt == 0; c++) begin
            out_ready = ($urandom_range(99) < ready_pct);
            ram_busy  = ($urandom_range(99) < busy_pct);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        ram_busy  = 1'b0;
        repeat (3) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic finish_xfer(input string tag);
        int n;
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_data"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        mon_en = 1'b0;
    endtask

    initial begin
        logic [7:0] t1_exp [4];
        logic [7:0] a0;
        int         d_cnt;
        int         v_cnt;

        reset     = 1'b1;
        start     = 1'b0;
        ram_busy  = 1'b0;
        out_ready = 1'b1;
        base_addr = '0;
        length    = '0;
        fill_ram(1'b0);
        repeat (3) begin
            @(posedge clock); #1;
        end
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_addr", 32'(ram_address), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_wren", 32'(ram_wren), 32'd0);
        reset = 1'b0;

        // Basic block read and latency
        t1_exp = '{8'h4A, 8'h4B, 8'h48, 8'h49};
        do_start(8'h10, 9'd4);
        check("t1_busy", 32'(busy), 32'd1);
        wait_done(100, 100, 0);
        check("t1_first_valid", 32'(first_valid_rel), 32'd4);
        check("t1_done_at", 32'(done_rel), 32'd8);
        for (int i = 0; i < 4 && i < got_q.size(); i++) check("t1_word", 32'(got_q[i]), 32'(t1_exp[i]));
        finish_xfer("t1");

        // Address wrap
        do_start(8'hFE, 9'd4);
        wait_done(100, 100, 0);
        finish_xfer("t2");

        // Sink stall: credit limit and held output
        out_ready = 1'b0;
        do_start(8'h20, 9'd5);
        repeat (9) begin
            @(posedge clock); #1;
        end
        check("t3_issued", 32'(ram_address), 32'(8'h20 + 8'(FD)));
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_head", 32'(out_data), 32'(exp_q[0]));
        wait_done(200, 100, 0);
        finish_xfer("t3");

        // ram_busy held at start
        ram_busy = 1'b1;
        do_start(8'h40, 9'd6);
        a0 = ram_address;
        repeat (6) begin
            @(posedge clock); #1;
        end
        check("t4_wait_addr", 32'(ram_address), 32'(a0));
        check("t4_wait_valid", 32'(out_valid), 32'd0);
        ram_busy = 1'b0;
        wait_done(200, 100, 0);
        check("t4_first_valid", 32'(first_valid_rel), 32'd11);
        finish_xfer("t4");

        // ram_busy pulses mid-transfer
        fill_ram(1'b1);
        do_start(8'hF0, 9'd30);
        wait_done(2000, 100, 40);
        finish_xfer("t4b");

        // Empty transfer
        do_start(8'h33, 9'd0);
        wait_done(100, 100, 0);
        check("t5_done_at", 32'(done_rel), 32'd2);
        check("t5_no_valid", 32'(first_valid_rel), 32'd0);
        finish_xfer("t5");

        // Clamped full-space transfer
        fill_ram(1'b0);
        do_start(8'h80, 9'h1FF);
        wait_done(1000, 100, 0);
        check("t5_full_done_at", 32'(done_rel), 32'd260);
        finish_xfer("t5_full");

        // Reset mid-transfer
        do_start(8'h05, 9'd20);
        repeat (5) begin
            @(posedge clock); #1;
        end
        mon_en = 1'b0;
        reset  = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_addr", 32'(ram_address), 32'd0);
        check("t6_data", 32'(out_data), 32'd0);
        d_cnt = 0;
        v_cnt = 0;
        repeat (12) begin
            @(posedge clock); #1;
            d_cnt += int'(done);
            v_cnt += int'(out_valid);
        end
        check("t6_no_done", 32'(d_cnt), 32'd0);
        check("t6_no_valid", 32'(v_cnt), 32'd0);
        do_start(8'h07, 9'd3);
        wait_done(100, 100, 0);
        check("t6_restart_done_at", 32'(done_rel), 32'd7);
        finish_xfer("t6_restart");

        // Randomized transfers
        for (int k = 0; k < 20; k++) begin
            logic [7:0] b;
            logic [8:0] l;
            fill_ram(1'b1);
            b = 8'($urandom);
            l = ($urandom_range(9) == 0) ? 9'($urandom_range(256, 511)) : 9'($urandom_range(0, 24));
            do_start(b, l);
            wait_done(4000, int'($urandom_range(30, 100)), int'($urandom_range(0, 40)));
            finish_xfer("rnd");
        end

        check("end_wren", 32'(ram_wren), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
